// File: rtl/regfile_read_port.sv
// Read side of a 16-entry register file: one-hot wordline writes, a busy
// scoreboard of pending writes, and a dual-operand read port with a registered response.
module regfile_read_port #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REGS   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REGS-1:0]   WriteWordline,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic                  IssueValid,
  input  logic [3:0]            IssueDst,
  input  logic                  ReqValid,
  output logic                  ReqReady,
  input  logic [3:0]            SrcReg1,
  input  logic [3:0]            SrcReg2,
  output logic                  RspValid,
  input  logic                  RspReady,
  output logic [DATA_WIDTH-1:0] SrcData1,
  output logic [DATA_WIDTH-1:0] SrcData2,
  output logic [NUM_REGS-1:0]   BusyVec
);

  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
  logic [NUM_REGS-1:0]   r_busy;
  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_src1;
  logic [DATA_WIDTH-1:0] r_src2;

  logic                  w_ok1;
  logic                  w_ok2;
  logic                  w_ready;
  logic                  w_fire;
  logic [DATA_WIDTH-1:0] w_data1;
  logic [DATA_WIDTH-1:0] w_data2;

  // An operand is usable if it is R0, not pending, or its producer writes this cycle.
  assign w_ok1 = (SrcReg1 == 4'd0) || !r_busy[SrcReg1] || WriteWordline[SrcReg1];
  assign w_ok2 = (SrcReg2 == 4'd0) || !r_busy[SrcReg2] || WriteWordline[SrcReg2];

  // Handshake: a request transfers on a cycle with ReqValid && ReqReady; a
  // response retires on a cycle with RspValid && RspReady. ReqReady looks at
  // the source IDs combinationally but never at ReqValid.
  assign w_ready = (!r_rsp_valid || RspReady) && w_ok1 && w_ok2;
  assign w_fire  = ReqValid && w_ready;

  // Same-cycle writes bypass the array so the accepted data is never stale.
  assign w_data1 = (SrcReg1 == 4'd0)        ? '0 :
                   WriteWordline[SrcReg1]   ? WriteData : r_regs[SrcReg1];
  assign w_data2 = (SrcReg2 == 4'd0)        ? '0 :
                   WriteWordline[SrcReg2]   ? WriteData : r_regs[SrcReg2];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
      r_busy      <= '0;
      r_rsp_valid <= 1'b0;
      r_src1      <= '0;
      r_src2      <= '0;
    end else begin
      // R0 is hardwired: its wordline bit and issues to it are ignored.
      r_regs[0] <= '0;
      r_busy[0] <= 1'b0;
      for (int i = 1; i < NUM_REGS; i++) begin
        if (WriteWordline[i]) begin
          r_regs[i] <= WriteData;
        end
        // A new issue outranks a completing write: the newer producer owns the register.
        if (IssueValid && (IssueDst == 4'(i))) begin
          r_busy[i] <= 1'b1;
        end else if (WriteWordline[i]) begin
          r_busy[i] <= 1'b0;
        end
      end

      if (w_fire) begin
        r_rsp_valid <= 1'b1;
        r_src1      <= w_data1;
        r_src2      <= w_data2;
      end else if (RspReady) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign ReqReady = w_ready;
  assign RspValid = r_rsp_valid;
  assign SrcData1 = r_src1;
  assign SrcData2 = r_src2;
  assign BusyVec  = r_busy;

endmodule

// File: tb/tb_regfile_read_port.sv
// Bench for regfile_read_port: write/read vector table, back-to-back reads,
// stall/bypass, backpressure, R0 and mid-transaction reset sequences.
module tb_regfile_read_port;

  localparam int W = 16;

  logic          clk;
  logic          rst_n;
  logic [15:0]   WriteWordline;
  logic [W-1:0]  WriteData;
  logic          IssueValid;
  logic [3:0]    IssueDst;
  logic          ReqValid;
  logic          ReqReady;
  logic [3:0]    SrcReg1;
  logic [3:0]    SrcReg2;
  logic          RspValid;
  logic          RspReady;
  logic [W-1:0]  SrcData1;
  logic [W-1:0]  SrcData2;
  logic [15:0]   BusyVec;

  regfile_read_port #(.DATA_WIDTH(W), .NUM_REGS(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .WriteWordline(WriteWordline), .WriteData(WriteData),
    .IssueValid(IssueValid), .IssueDst(IssueDst),
    .ReqValid(ReqValid), .ReqReady(ReqReady),
    .SrcReg1(SrcReg1), .SrcReg2(SrcReg2),
    .RspValid(RspValid), .RspReady(RspReady),
    .SrcData1(SrcData1), .SrcData2(SrcData2),
    .BusyVec(BusyVec)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [2*W-1:0] exp_q[$];

  typedef struct {
    logic [15:0]  wl;
    logic [W-1:0] wd;
    logic [3:0]   s1;
    logic [3:0]   s2;
    logic [W-1:0] e1;
    logic [W-1:0] e2;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic write_reg(input logic [15:0] wl, input logic [W-1:0] d);
    WriteWordline = wl;
    WriteData     = d;
    tick();
    WriteWordline = '0;
  endtask

  task automatic issue(input logic [3:0] dst);
    IssueValid = 1'b1;
    IssueDst   = dst;
    tick();
    IssueValid = 1'b0;
  endtask

  // Presents a request until accepted (bounded) and queues its expected data.
  task automatic request(input logic [3:0] s1, input logic [3:0] s2,
                         input logic [W-1:0] e1, input logic [W-1:0] e2,
                         output int waited);
    SrcReg1  = s1;
    SrcReg2  = s2;
    ReqValid = 1'b1;
    waited   = 0;
    while (!ReqReady && waited < 20) begin
      tick();
      waited++;
    end
    if (ReqReady) begin
      exp_q.push_back({e1, e2});
      tick();
    end else begin
      check("req_timeout", 32'(waited), 32'd0);
    end
    ReqValid = 1'b0;
  endtask

  // scoreboard: compare each retiring response against the queue head
  always @(negedge clk) begin
    if (rst_n && RspValid && RspReady) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", 32'(RspValid), 32'd0);
      end else begin
        logic [2*W-1:0] e;
        e = exp_q.pop_front();
        check("rsp_src1", 32'(SrcData1), 32'(e[2*W-1:W]));
        check("rsp_src2", 32'(SrcData2), 32'(e[W-1:0]));
      end
    end
  end

  initial begin
    int waited;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    vecs[0] = '{16'h0020, 16'h1234, 4'd5,  4'd0, 16'h1234, 16'h0000};
    vecs[1] = '{16'h0006, 16'hA5A5, 4'd1,  4'd2, 16'hA5A5, 16'hA5A5};
    vecs[2] = '{16'h0400, 16'h0F0F, 4'd10, 4'd5, 16'h0F0F, 16'h1234};
    vecs[3] = '{16'h8000, 16'hFFFF, 4'd15, 4'd1, 16'hFFFF, 16'hA5A5};
    vecs[4] = '{16'h0001, 16'hFFFF, 4'd0,  4'd0, 16'h0000, 16'h0000};
    vecs[5] = '{16'h0004, 16'h5555, 4'd2,  4'd1, 16'h5555, 16'hA5A5};

    rst_n = 1'b0; WriteWordline = '0; WriteData = '0; IssueValid = 1'b0;
    IssueDst = '0; ReqValid = 1'b0; SrcReg1 = '0; SrcReg2 = '0; RspReady = 1'b1;
    tick(); tick();
    rst_n = 1'b1;
    check("rst_rspvalid", 32'(RspValid), 32'd0);
    check("rst_busy", 32'(BusyVec), 32'd0);
    check("rst_data1", 32'(SrcData1), 32'd0);
    check("rst_data2", 32'(SrcData2), 32'd0);
    check("rst_ready", 32'(ReqReady), 32'd1);

    // table-driven write-then-read vectors
    for (int i = 0; i < 6; i++) begin
      write_reg(vecs[i].wl, vecs[i].wd);
      request(vecs[i].s1, vecs[i].s2, vecs[i].e1, vecs[i].e2, waited);
      check("vec_wait", 32'(waited), 32'd0);
      tick();
    end

    // back-to-back reads at one per cycle
    ra = 16'($urandom_range(1, 16'hFFFF));
    rb = 16'($urandom_range(1, 16'hFFFF));
    write_reg(16'h0100, ra);
    write_reg(16'h0200, rb);
    request(4'd8, 4'd9, ra, rb, waited);
    check("b2b_wait0", 32'(waited), 32'd0);
    request(4'd9, 4'd8, rb, ra, waited);
    check("b2b_wait1", 32'(waited), 32'd0);
    request(4'd8, 4'd8, ra, ra, waited);
    check("b2b_wait2", 32'(waited), 32'd0);
    tick();

    // stall on busy R3, released by a bypassed write
    issue(4'd3);
    check("busy_r3", 32'(BusyVec), 32'h0008);
    SrcReg1 = 4'd3; SrcReg2 = 4'd5; ReqValid = 1'b1;
    #1 check("stall_r3_a", 32'(ReqReady), 32'd0);
    tick();
    check("stall_r3_b", 32'(ReqReady), 32'd0);
    WriteWordline = 16'h0008; WriteData = 16'hBEEF;
    #1 check("bypass_ready", 32'(ReqReady), 32'd1);
    if (ReqReady) exp_q.push_back({16'hBEEF, 16'h1234});
    tick();
    WriteWordline = '0; ReqValid = 1'b0;
    check("busy_cleared", 32'(BusyVec), 32'h0000);
    tick();

    // issue and write to R7 in the same cycle: the issue wins
    IssueValid = 1'b1; IssueDst = 4'd7;
    write_reg(16'h0080, 16'h7777);
    IssueValid = 1'b0;
    check("set_wins", 32'(BusyVec), 32'h0080);
    SrcReg1 = 4'd7; SrcReg2 = 4'd0; ReqValid = 1'b1;
    #1 check("stall_r7", 32'(ReqReady), 32'd0);
    tick();
    check("stall_r7_b", 32'(ReqReady), 32'd0);
    ReqValid = 1'b0;
    write_reg(16'h0080, 16'h7070);
    check("busy_r7_clr", 32'(BusyVec), 32'h0000);
    request(4'd7, 4'd0, 16'h7070, 16'h0000, waited);
    check("r7_wait", 32'(waited), 32'd0);
    tick();

    // backpressure: response held for 3 cycles
    RspReady = 1'b0;
    request(4'd5, 4'd1, 16'h1234, 16'hA5A5, waited);
    SrcReg1 = 4'd2; SrcReg2 = 4'd2; ReqValid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      check("bp_ready", 32'(ReqReady), 32'd0);
      check("bp_valid", 32'(RspValid), 32'd1);
      check("bp_hold1", 32'(SrcData1), 32'h1234);
      check("bp_hold2", 32'(SrcData2), 32'hA5A5);
      tick();
    end
    RspReady = 1'b1;
    #1 check("bp_release", 32'(ReqReady), 32'd1);
    if (ReqReady) exp_q.push_back({16'h5555, 16'h5555});
    tick();
    ReqValid = 1'b0;
    tick();

    // R0: issue to R0 never marks busy, reads return zero
    write_reg(16'h0001, 16'hFFFF);
    issue(4'd0);
    check("r0_busy", 32'(BusyVec), 32'h0000);
    request(4'd0, 4'd0, 16'h0000, 16'h0000, waited);
    check("r0_wait", 32'(waited), 32'd0);
    tick();

    // reset mid-transaction
    write_reg(16'h0010, 16'h4444);
    issue(4'd4); issue(4'd5); issue(4'd6); issue(4'd7);
    check("busy_f0", 32'(BusyVec), 32'h00F0);
    RspReady = 1'b0;
    SrcReg1 = 4'd1; SrcReg2 = 4'd1; ReqValid = 1'b1;
    #1 check("pre_rst_ready", 32'(ReqReady), 32'd1);
    tick();
    ReqValid = 1'b0;
    check("pre_rst_valid", 32'(RspValid), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    RspReady = 1'b1;
    check("mid_rst_valid", 32'(RspValid), 32'd0);
    check("mid_rst_busy", 32'(BusyVec), 32'h0000);
    request(4'd4, 4'd0, 16'h0000, 16'h0000, waited);
    check("post_rst_wait", 32'(waited), 32'd0);
    tick(); tick();

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_read_port.md
Name: regfile_read_port

Overview:
- Read side of the 16-entry register file. Pairs with the write-side 4-to-16 one-hot wordline decoder.
- Holds the register array, which is written by one-hot wordlines.
- Serves dual-operand read requests over a valid/ready handshake, with a registered response.
- Keeps a busy scoreboard of pending writes. A request stalls until both of its sources are either not busy or being bypassed from the same-cycle write.

Parameters:
DATA_WIDTH, 16, register and data width
NUM_REGS, 16, number of registers; fixed, because the wordline width and the 4-bit register IDs depend on it

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous active-low reset
WriteWordline  input  16  one-hot write enables from the write decoder; all-zero means no write
WriteData  input  DATA_WIDTH  write data, applied to every register whose wordline bit is set
IssueValid  input  1  an instruction with a destination register has been issued
IssueDst  input  4  destination register ID of the issued instruction
ReqValid  input  1  read request valid
ReqReady  output  1  read request can be accepted this cycle
SrcReg1  input  4  first source register ID
SrcReg2  input  4  second source register ID
RspValid  output  1  response data valid
RspReady  input  1  consumer accepts the response
SrcData1  output  DATA_WIDTH  read data for SrcReg1
SrcData2  output  DATA_WIDTH  read data for SrcReg2
BusyVec  output  16  current scoreboard; bit i set means register i has a write pending

Behaviour:
- Reset: clk and rst_n are the clock and reset. Reset is synchronous and active-low: sampled on the rising edge of clk while rst_n=0.
  - Clears all registers to 0 and BusyVec to 0.
  - Clears RspValid to 0 and SrcData1/SrcData2 to 0.
  - Reset mid-transaction drops any pending response and clears all busy bits.
- R0:
  - Always reads 0.
  - Wordline bit 0 is ignored.
  - IssueDst=0 never sets busy, so BusyVec[0] is always 0.
- Write: on each rising edge, every register i≠0 with WriteWordline[i]=1 loads WriteData. If more than one bit is set, all of those registers are written.
- Scoreboard, per bit i≠0:
  - Set when IssueValid=1 and IssueDst=i.
  - Cleared when WriteWordline[i]=1.
  - If set and clear happen in the same cycle, set wins: the new producer takes over.
  - BusyVec shows the registered state.
- Operand availability, per source s, evaluated combinationally:
  - ok(s) = (s==0) OR !BusyVec[s] OR WriteWordline[s].
  - Bypass: if WriteWordline[s]=1 in the accepting cycle, the captured data is WriteData, not the stale array value.
- Handshake:
  - ReqReady = (!RspValid OR RspReady) AND ok(SrcReg1) AND ok(SrcReg2).
  - ReqReady may depend on ReqValid's sources combinationally. ReqValid must not depend on ReqReady.
  - A transfer happens when ReqValid AND ReqReady.
- Latency:
  - On a transfer, SrcData1/2 are registered and RspValid=1 on the next edge. That is 1-cycle latency.
  - Back-to-back transfers at one per cycle are allowed while RspReady=1.
- Backpressure: while RspValid=1 and RspReady=0, SrcData1/2 and RspValid hold stable and ReqReady=0.
- Response retire: with RspValid=1, RspReady=1 and no new transfer, RspValid drops to 0 on the next edge. Data may hold its old value.
- Same-cycle issue and request: an issue to a register in the same cycle as a request reading it does not stall that request. The request sees the pre-issue BusyVec; the RAW ordering is the issuer's responsibility.
- Both sources equal: stall and bypass are evaluated identically for both, so both outputs carry the same value.

Test Plan:
- Reset, then write R5=0x1234 via wordline 0x0020, then request (5,0) with RspReady=1 -> next cycle RspValid=1, SrcData1=0x1234, SrcData2=0x0000.
- Issue Dst=3, then request (3,5) -> ReqReady=0 and BusyVec=0x0008. Then apply wordline 0x0008 with data 0xBEEF -> accepted in that same cycle (bypass), SrcData1=0xBEEF, and BusyVec=0x0000 on the next cycle.
- Issue Dst=7 and wordline 0x0080 in the same cycle -> BusyVec[7]=1 afterward, and a read of R7 stalls.
- Response pending with RspReady=0 for 3 cycles while ReqValid=1 -> ReqReady=0 throughout, SrcData held. Raise RspReady -> the next request is accepted in the same cycle.
- Write wordline 0x0001 with 0xFFFF, then issue Dst=0, then read (0,0) -> BusyVec=0, no stall, both outputs 0x0000.
- Set busy bits 0x00F0 and a pending response, then hold rst_n=0 for one edge -> RspValid=0, BusyVec=0, and a subsequent read of R4 returns 0x0000.
